group_credit_fifo: RTL and testbench
====================================

Name: group_credit_fifo

Overview:
Elastic buffer between the SFTM output stream (producer) and the DPM FIFO-side input (consumer). Stores transformed group words in a first-word-fall-through FIFO and tags the last word of each group. Keeps a group credit counter: SFTM may only begin a new group while a credit is available. A credit is returned when DPM pops the last word of a group. Exports full/empty/count/credit status to global_controller.

Parameters:
DATA_W, 16, width of one data word
FIFO_DEPTH, 8, number of entries; power of two, >= 2
MAX_CREDITS, 2, groups allowed in flight between SFTM and DPM; >= 1
CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived, not overridden)
CRED_W, $clog2(MAX_CREDITS+1), credit counter width (derived)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of contents, credits and flags
in_data  in  DATA_W  group word from SFTM (group_data)
in_valid  in  1  word present (group_data_valid)
in_last  in  1  qualifies in_valid: final word of the group
in_ready  out  1  = !fifo_full
fifo_data  out  DATA_W  head entry, valid when fifo_data_valid
fifo_data_valid  out  1  = !fifo_empty
fifo_last  out  1  last-of-group tag of the head entry
fifo_pop  in  1  DPM consumes the head this cycle
fifo_full  out  1  occupancy == FIFO_DEPTH
fifo_empty  out  1  occupancy == 0
fifo_count  out  CNT_W  current occupancy
credit_available  out  1  credits != 0
credits  out  CRED_W  current credit count
groups_buffered  out  CRED_W  complete groups (last word written) not yet popped
overflow_err  out  1  sticky: write dropped
underflow_err  out  1  sticky: pop while empty

Behaviour:
- Reset (rst_n=0 at a clock edge) and flush=1 have identical effect: pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, fifo_data_valid=0, fifo_last=0, fifo_data=0, in_ready=1, credits=MAX_CREDITS, credit_available=1, groups_buffered=0, in_group=0, overflow_err=0, underflow_err=0. Reset has priority over flush. Both may occur mid-group; any partial group is discarded.
- Accept: accept = in_valid && !fifo_full && (in_group || credits!=0).
- Write: the word and in_last are written at the write pointer on the accept edge. They are visible on fifo_data/fifo_last the next cycle if the FIFO was empty (1-cycle latency).
- in_ready does not depend on fifo_pop. A write while full is dropped even if a pop happens in the same cycle.
- Pop: pop = fifo_pop && !fifo_empty. The read pointer advances and the next head appears on the following cycle.
- fifo_pop while empty is ignored and sets underflow_err. This includes the cycle where a write into an empty FIFO occurs; that word is retained.
- Group tracking: in_group is set on an accepted word with in_last=0. It clears on an accepted word with in_last=1.
- A credit is consumed on an accepted word while in_group=0 (first word of a group). A single-word group (in_last=1 on the first word) consumes one credit.
- A credit is returned on a pop whose head has fifo_last=1.
- Consume and return in the same cycle: credits unchanged. Credits saturate at 0 and MAX_CREDITS; returning at MAX_CREDITS sets underflow_err.
- groups_buffered increments on an accepted in_last word and decrements on a pop of a last-tagged word. Both in one cycle: unchanged.
- Dropped write: in_valid=1 with fifo_full=1, or with in_group=0 and credits=0. It sets overflow_err; no state other than the flag changes.
- fifo_count updates by +1, -1 or 0. Simultaneous accept and pop on a non-empty, non-full FIFO keeps the count.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count, not from pointer compare.
- Error flags clear only on reset or flush.

Decomposition:
- Package vidc_pkg holds: the DATA_W default, FIFO_DEPTH and MAX_CREDITS defaults, and a struct {logic last; logic [DATA_W-1:0] data} fifo_entry_t.
- One sub-module, fifo_store: register array plus write/read pointers and occupancy counter, with push/pop/flush inputs.
- Credit, group and error logic stays in group_credit_fifo.

Test Plan:
- Reset, then push 3 words A1,A2,A3 (last on A3). Expect: fifo_count=3, credits=1, groups_buffered=1. fifo_data=A1 one cycle after the first write. Popping 3 words yields A1..A3 with fifo_last on A3, then credits=2 and fifo_empty=1.
- Push two 2-word groups without popping, then present a third group's first word. Expect: credits=0, credit_available=0, word dropped, overflow_err=1, fifo_count=4. Pop the first group. Expect credits=1.
- Push 9 words continuously (MAX_CREDITS=2, one group, last on word 9). Expect: fifo_full=1 after 8 words, in_ready=0, word 9 dropped, overflow_err=1, fifo_count=8.
- Steady stream: accept and pop every cycle for 20 cycles over a 5-word group length. Expect: fifo_count constant at 1, credits never below 0, wrap of pointers with data order preserved, no error flags.
- fifo_pop on an empty FIFO with a simultaneous first write. Expect: underflow_err=1, fifo_count=1, the written word at the head next cycle.
- Mid-group flush after 2 of 4 words. Expect: next cycle fifo_count=0, credits=2, in_group=0, errors cleared. A following new group is accepted normally.

Source files
------------

// File: rtl/group_credit_fifo_pkg.sv
// vidc_pkg: shared defaults and the FIFO entry layout used by the
// group credit FIFO and its storage sub-module.
//   DATA_W          : width of one group data word
//   FIFO_DEPTH_DEF  : default number of FIFO entries (power of two, >= 2)
//   MAX_CREDITS_DEF : default number of groups allowed in flight
//   fifo_entry_t    : one stored word plus its last-of-group tag
package vidc_pkg;

  localparam int DATA_W          = 16;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int MAX_CREDITS_DEF = 2;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/group_credit_fifo_if.sv
// group_credit_fifo_if: bundles the producer stream (SFTM), the consumer
// FIFO side (DPM) and the status outputs seen by global_controller.
//   master : the environment side (drives in_* and fifo_pop)
//   slave  : the group_credit_fifo side (drives ready, head and status)
interface group_credit_fifo_if
  import vidc_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int MAX_CREDITS = MAX_CREDITS_DEF
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W = $clog2(MAX_CREDITS + 1);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_data_valid;
  logic              fifo_last;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_available;
  logic [CRED_W-1:0] credits;
  logic [CRED_W-1:0] groups_buffered;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output in_data, in_valid, in_last, fifo_pop,
    input  in_ready, fifo_data, fifo_data_valid, fifo_last, fifo_full,
           fifo_empty, fifo_count, credit_available, credits,
           groups_buffered, overflow_err, underflow_err
  );

  modport slave (
    input  in_data, in_valid, in_last, fifo_pop,
    output in_ready, fifo_data, fifo_data_valid, fifo_last, fifo_full,
           fifo_empty, fifo_count, credit_available, credits,
           groups_buffered, overflow_err, underflow_err
  );

endinterface

// File: rtl/group_credit_fifo_fifo_store.sv
// fifo_store: first-word-fall-through register array with write/read
// pointers and an occupancy counter. Full/empty come from the counter so
// the pointers can simply wrap.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush_i     : synchronous clear of pointers and count
//   push_i      : write wr_entry_i at the write pointer (caller guarantees !full)
//   pop_i       : advance the read pointer (caller guarantees !empty)
//   head_o      : entry at the read pointer, all-zero while empty
//   count_o     : occupancy, full_o / empty_o derived from it
module fifo_store
  import vidc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  fifo_entry_t      wr_entry_i,
  output fifo_entry_t      head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && push_i) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/group_credit_fifo.sv
// group_credit_fifo: elastic buffer between the SFTM output stream and the
// DPM FIFO-side input. Words are stored with a last-of-group tag; a new
// group may only start while a group credit is available, and the credit
// comes back when DPM pops the last word of a group.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   flush : synchronous clear of contents, credits and error flags
//   bus   : producer, consumer and status signals (slave modport)
module group_credit_fifo
  import vidc_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int MAX_CREDITS = MAX_CREDITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  group_credit_fifo_if.slave  bus
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W = $clog2(MAX_CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_CREDITS);

  fifo_entry_t      wr_entry;
  fifo_entry_t      head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  logic [CRED_W-1:0] credits_q, credits_d;
  logic [CRED_W-1:0] groups_q, groups_d;
  logic              in_group_q, in_group_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic accept, pop, consume, give_back, last_in, last_out;

  assign wr_entry.last = bus.in_last;
  assign wr_entry.data = bus.in_data;

  // A continuing group never needs a credit; only its first word does.
  assign accept    = bus.in_valid && !full && (in_group_q || (credits_q != '0));
  assign pop       = bus.fifo_pop && !empty;
  assign consume   = accept && !in_group_q;
  assign give_back = pop && head.last;
  assign last_in   = accept && bus.in_last;
  assign last_out  = pop && head.last;

  fifo_store #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .push_i     (accept),
    .pop_i      (pop),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    credits_d  = credits_q;
    groups_d   = groups_q;
    in_group_d = in_group_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (accept) in_group_d = !bus.in_last;

    if (bus.in_valid && !accept) ovf_d = 1'b1;
    if (bus.fifo_pop && empty)   unf_d = 1'b1;

    // Consume and return in the same cycle cancel out.
    if (consume && !give_back) begin
      if (credits_q != '0) credits_d = credits_q - 1'b1;
    end else if (give_back && !consume) begin
      if (credits_q == CRED_MAX) unf_d = 1'b1;
      else                       credits_d = credits_q + 1'b1;
    end

    if (last_in && !last_out) begin
      if (groups_q != CRED_MAX) groups_d = groups_q + 1'b1;
    end else if (last_out && !last_in) begin
      if (groups_q != '0) groups_d = groups_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      credits_q  <= CRED_MAX;
      groups_q   <= '0;
      in_group_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      groups_q   <= groups_d;
      in_group_q <= in_group_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.in_ready         = !full;
  assign bus.fifo_data        = head.data;
  assign bus.fifo_last        = head.last;
  assign bus.fifo_data_valid  = !empty;
  assign bus.fifo_full        = full;
  assign bus.fifo_empty       = empty;
  assign bus.fifo_count       = count;
  assign bus.credit_available = (credits_q != '0);
  assign bus.credits          = credits_q;
  assign bus.groups_buffered  = groups_q;
  assign bus.overflow_err     = ovf_q;
  assign bus.underflow_err    = unf_q;

endmodule

// File: tb/tb_group_credit_fifo.sv
// Testbench for group_credit_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the buffer rules.
module tb_group_credit_fifo;
  import vidc_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXC  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  group_credit_fifo_if #(.FIFO_DEPTH(DEPTH), .MAX_CREDITS(MAXC)) bus ();

  group_credit_fifo #(.FIFO_DEPTH(DEPTH), .MAX_CREDITS(MAXC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit          last;
    logic [15:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_cred   = MAXC;
  int   m_groups = 0;
  bit   m_ingrp  = 0;
  bit   m_ovf    = 0;
  bit   m_unf    = 0;

  function automatic logic [15:0] exp_data();
    return (mq.size() == 0) ? 16'h0 : mq[0].data;
  endfunction

  function automatic bit exp_last();
    return (mq.size() == 0) ? 1'b0 : mq[0].last;
  endfunction

  // Apply one cycle of inputs, advance the reference model at the edge,
  // and leave the caller 1 time unit after the edge to sample outputs.
  task automatic tick(input bit v, input bit l, input logic [15:0] d,
                      input bit p, input bit fl = 1'b0, input bit rs = 1'b1);
    bit full, empty, acc, popped, hl;
    int delta;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
    bus.fifo_pop = p;
    flush        = fl;
    rst_n        = rs;
    @(posedge clk);
    if (!rs || fl) begin
      mq.delete();
      m_cred = MAXC; m_groups = 0; m_ingrp = 0; m_ovf = 0; m_unf = 0;
    end else begin
      full   = (mq.size() == DEPTH);
      empty  = (mq.size() == 0);
      acc    = v && !full && (m_ingrp || m_cred > 0);
      popped = p && !empty;
      hl     = popped && mq[0].last;
      if (p && empty) m_unf = 1;
      if (v && !acc)  m_ovf = 1;
      delta = int'(hl) - int'(acc && !m_ingrp);
      if (delta > 0 && m_cred == MAXC) m_unf = 1;
      else m_cred += delta;
      m_groups += int'(acc && l) - int'(hl);
      if (m_groups < 0) m_groups = 0;
      if (acc) m_ingrp = !l;
      if (popped) void'(mq.pop_front());
      if (acc) mq.push_back('{l, d});
    end
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic do_flush();
    tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count); end
    n_checks++; if ({bus.fifo_empty, bus.fifo_full, bus.fifo_data_valid, bus.in_ready} !== 4'b1001) begin
      n_err++; $display("FAIL reset_flags got e%b f%b v%b r%b exp e1 f0 v0 r1", bus.fifo_empty, bus.fifo_full, bus.fifo_data_valid, bus.in_ready); end
    n_checks++; if ({bus.fifo_data, bus.fifo_last} !== 17'h0) begin n_err++; $display("FAIL reset_head got %h/%b exp 0/0", bus.fifo_data, bus.fifo_last); end
    n_checks++; if (bus.credits !== 2'd2 || bus.credit_available !== 1'b1) begin
      n_err++; $display("FAIL reset_credits got %0d/%b exp 2/1", bus.credits, bus.credit_available); end
    n_checks++; if ({bus.groups_buffered, bus.overflow_err, bus.underflow_err} !== 4'b0) begin
      n_err++; $display("FAIL reset_groups_err got g%0d o%b u%b exp 0", bus.groups_buffered, bus.overflow_err, bus.underflow_err); end
    idle();
  endtask

  task automatic test_single_group();
    logic [15:0] a [3];
    for (int i = 0; i < 3; i++) a[i] = 16'($urandom);
    tick(1'b1, 1'b0, a[0], 1'b0);
    n_checks++; if (bus.fifo_data !== a[0] || bus.fifo_data_valid !== 1'b1) begin
      n_err++; $display("FAIL sg_first_latency got %h v%b exp %h v1", bus.fifo_data, bus.fifo_data_valid, a[0]); end
    tick(1'b1, 1'b0, a[1], 1'b0);
    tick(1'b1, 1'b1, a[2], 1'b0);
    n_checks++; if (bus.fifo_count !== 4'd3) begin n_err++; $display("FAIL sg_count got %0d exp 3", bus.fifo_count); end
    n_checks++; if (bus.credits !== 2'd1) begin n_err++; $display("FAIL sg_credits got %0d exp 1", bus.credits); end
    n_checks++; if (bus.groups_buffered !== 2'd1) begin n_err++; $display("FAIL sg_groups got %0d exp 1", bus.groups_buffered); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.fifo_data !== a[i] || bus.fifo_last !== (i == 2)) begin
        n_err++; $display("FAIL sg_pop%0d got %h/%b exp %h/%b", i, bus.fifo_data, bus.fifo_last, a[i], (i == 2)); end
      tick(1'b0, 1'b0, 16'h0, 1'b1);
    end
    n_checks++; if (bus.credits !== 2'd2 || bus.fifo_empty !== 1'b1) begin
      n_err++; $display("FAIL sg_drained got cred %0d empty %b exp 2/1", bus.credits, bus.fifo_empty); end
  endtask

  task automatic test_credit_block();
    for (int i = 0; i < 4; i++) tick(1'b1, (i % 2) == 1, 16'(16'h1000 + i), 1'b0);
    tick(1'b1, 1'b0, 16'h2000, 1'b0);
    n_checks++; if (bus.credits !== 2'd0 || bus.credit_available !== 1'b0) begin
      n_err++; $display("FAIL cb_credits got %0d/%b exp 0/0", bus.credits, bus.credit_available); end
    n_checks++; if (bus.overflow_err !== 1'b1 || bus.fifo_count !== 4'd4) begin
      n_err++; $display("FAIL cb_drop got ovf %b count %0d exp 1/4", bus.overflow_err, bus.fifo_count); end
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (bus.credits !== 2'd1 || bus.fifo_data !== 16'h1002) begin
      n_err++; $display("FAIL cb_return got cred %0d head %h exp 1/1002", bus.credits, bus.fifo_data); end
    do_flush();
    n_checks++; if (bus.overflow_err !== 1'b0 || bus.credits !== 2'd2) begin
      n_err++; $display("FAIL cb_flush got ovf %b cred %0d exp 0/2", bus.overflow_err, bus.credits); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, i == 8, 16'(16'h3000 + i), 1'b0);
      if (i == 7) begin
        n_checks++; if (bus.fifo_full !== 1'b1 || bus.in_ready !== 1'b0) begin
          n_err++; $display("FAIL full_at8 got full %b ready %b exp 1/0", bus.fifo_full, bus.in_ready); end
      end
    end
    n_checks++; if (bus.overflow_err !== 1'b1 || bus.fifo_count !== 4'd8) begin
      n_err++; $display("FAIL full_drop got ovf %b count %0d exp 1/8", bus.overflow_err, bus.fifo_count); end
    // Write while full with a same-cycle pop is still dropped.
    tick(1'b1, 1'b1, 16'h3FFF, 1'b1);
    n_checks++; if (bus.fifo_count !== 4'd7 || bus.groups_buffered !== 2'd0) begin
      n_err++; $display("FAIL full_pop_drop got count %0d groups %0d exp 7/0", bus.fifo_count, bus.groups_buffered); end
    do_flush();
  endtask

  task automatic test_stream();
    logic [15:0] d [21];
    int bad = 0;
    for (int i = 0; i < 21; i++) d[i] = 16'($urandom);
    tick(1'b1, 1'b0, d[0], 1'b0);
    for (int c = 1; c <= 20; c++) begin
      tick(1'b1, (c % 5) == 4, d[c], 1'b1);
      n_checks++; if (bus.fifo_count !== 4'd1 || bus.fifo_data !== d[c]) begin
        n_err++; $display("FAIL stream_c%0d got count %0d head %h exp 1/%h", c, bus.fifo_count, bus.fifo_data, d[c]); end
      if (bus.credits !== 2'(m_cred)) bad++;
    end
    n_checks++; if (bad != 0) begin n_err++; $display("FAIL stream_credits got %0d bad cycles exp 0", bad); end
    n_checks++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      n_err++; $display("FAIL stream_err got o%b u%b exp 0/0", bus.overflow_err, bus.underflow_err); end
    do_flush();
  endtask

  task automatic test_pop_empty_write();
    logic [15:0] w;
    w = 16'($urandom);
    tick(1'b1, 1'b1, w, 1'b1);
    n_checks++; if (bus.underflow_err !== 1'b1 || bus.fifo_count !== 4'd1) begin
      n_err++; $display("FAIL pe_flags got unf %b count %0d exp 1/1", bus.underflow_err, bus.fifo_count); end
    n_checks++; if (bus.fifo_data !== w || bus.fifo_last !== 1'b1) begin
      n_err++; $display("FAIL pe_head got %h/%b exp %h/1", bus.fifo_data, bus.fifo_last, w); end
    do_flush();
  endtask

  task automatic test_flush_mid_group();
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    tick(1'b1, 1'b0, 16'h4000, 1'b0);
    tick(1'b1, 1'b0, 16'h4001, 1'b0);
    do_flush();
    n_checks++; if (bus.fifo_count !== 4'd0 || bus.credits !== 2'd2) begin
      n_err++; $display("FAIL fl_state got count %0d cred %0d exp 0/2", bus.fifo_count, bus.credits); end
    n_checks++; if (bus.underflow_err !== 1'b0 || bus.overflow_err !== 1'b0) begin
      n_err++; $display("FAIL fl_err got u%b o%b exp 0/0", bus.underflow_err, bus.overflow_err); end
    tick(1'b1, 1'b0, 16'h5000, 1'b0);
    tick(1'b1, 1'b1, 16'h5001, 1'b0);
    n_checks++; if (bus.credits !== 2'd1 || bus.groups_buffered !== 2'd1 || bus.fifo_count !== 4'd2) begin
      n_err++; $display("FAIL fl_newgrp got cred %0d grp %0d count %0d exp 1/1/2", bus.credits, bus.groups_buffered, bus.fifo_count); end
    n_checks++; if (bus.fifo_data !== 16'h5000) begin n_err++; $display("FAIL fl_head got %h exp 5000", bus.fifo_data); end
    do_flush();
  endtask

  task automatic test_random();
    bit v, l, p, fl;
    logic [6:0] exp_flags;
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 99) < 60);
      l  = ($urandom_range(0, 2) == 0);
      p  = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) == 0);
      tick(v, l, 16'($urandom), p, fl);
      exp_flags = {mq.size() == DEPTH, mq.size() == 0, mq.size() != 0, mq.size() != DEPTH,
                   m_cred != 0, m_ovf, m_unf};
      n_checks++; if (bus.fifo_count !== 4'(mq.size())) begin
        n_err++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, bus.fifo_count, mq.size()); end
      n_checks++; if (bus.fifo_data !== exp_data() || bus.fifo_last !== exp_last()) begin
        n_err++; $display("FAIL rnd_head c%0d got %h/%b exp %h/%b", c, bus.fifo_data, bus.fifo_last, exp_data(), exp_last()); end
      n_checks++; if (bus.credits !== 2'(m_cred) || bus.groups_buffered !== 2'(m_groups)) begin
        n_err++; $display("FAIL rnd_cred c%0d got %0d/%0d exp %0d/%0d", c, bus.credits, bus.groups_buffered, m_cred, m_groups); end
      n_checks++; if ({bus.fifo_full, bus.fifo_empty, bus.fifo_data_valid, bus.in_ready,
                       bus.credit_available, bus.overflow_err, bus.underflow_err} !== exp_flags) begin
        n_err++; $display("FAIL rnd_flags c%0d got %b exp %b", c,
          {bus.fifo_full, bus.fifo_empty, bus.fifo_data_valid, bus.in_ready,
           bus.credit_available, bus.overflow_err, bus.underflow_err}, exp_flags); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    bus.fifo_pop = 1'b0;
    test_reset();
    test_single_group();
    test_credit_block();
    test_full();
    test_stream();
    test_pop_empty_write();
    test_flush_mid_group();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
